// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment types and the hex glyph table.
// Glyphs are active low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t GLYPH_0 = 7'h40;
    localparam seg_t GLYPH_1 = 7'h79;
    localparam seg_t GLYPH_2 = 7'h24;
    localparam seg_t GLYPH_3 = 7'h30;
    localparam seg_t GLYPH_4 = 7'h19;
    localparam seg_t GLYPH_5 = 7'h12;
    localparam seg_t GLYPH_6 = 7'h02;
    localparam seg_t GLYPH_7 = 7'h78;
    localparam seg_t GLYPH_8 = 7'h00;
    localparam seg_t GLYPH_9 = 7'h10;
    localparam seg_t GLYPH_A = 7'h08;
    localparam seg_t GLYPH_B = 7'h03;
    localparam seg_t GLYPH_C = 7'h46;
    localparam seg_t GLYPH_D = 7'h21;
    localparam seg_t GLYPH_E = 7'h06;
    localparam seg_t GLYPH_F = 7'h0E;
    localparam seg_t GLYPH [16] = '{
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
        GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
    };
endpackage

// File: rtl/seg_decode.sv
// seg_decode: hex nibble to active-low seven-segment glyph.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);
    assign seg = GLYPH[nib];
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed hex display driver with frame-latched value,
// leading-zero blanking, decimal points, PWM brightness and anode guard interval.
module sevenseg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2,
    parameter int BRIGHT_W = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  enable,
    output seg_t                  seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] WIN_LO = CW'(GUARD);
    localparam logic [CW-1:0] WIN_HI = CW'(SCAN_DIV - GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [BRIGHT_W-1:0] pwm;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   lz;
    logic [DIGITS-1:0]   an_nx;
    logic [3:0]          nib;
    seg_t                glyph;
    logic                slot_end;
    logic                frame_end;
    logic                zero_run;
    logic                lit;
    logic                on;

    assign slot_end  = cnt == CNT_LAST;
    assign frame_end = slot_end && idx == IDX_LAST;
    assign nib       = sh_val[4*idx +: 4];
    assign lit       = &bright || pwm < bright;
    assign on        = enable && cnt >= WIN_LO && cnt <= WIN_HI && lit &&
                       !(blank_lz && lz[idx] && !sh_dp[idx]);

    // lz[i] is set when every shadow nibble from the top down to i is zero
    always_comb begin
        lz = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && sh_val[4*i +: 4] == 4'h0;
            lz[i] = zero_run;
        end
    end

    always_comb begin
        an_nx = '1;
        an_nx[idx] = !on;
    end

    seg_decode u_dec (
        .nib (nib),
        .seg (glyph)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt        <= '0;
            idx        <= '0;
            pwm        <= '0;
            sh_val     <= '0;
            sh_dp      <= '0;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end)
                idx <= idx == IDX_LAST ? '0 : idx + IW'(1);
            pwm <= pwm + BRIGHT_W'(1);
            if (frame_end) begin
                sh_val <= value;
                sh_dp  <= dp;
            end
            frame_done <= frame_end;
            an         <= an_nx;
            seg        <= on ? glyph : SEG_BLANK;
            dp_n       <= !(on && sh_dp[idx]);
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed checks of scan timing, frame latching, blanking,
// PWM, enable and asynchronous reset for a 4-digit, 8-cycle-slot display.
module tb_sevenseg_scan;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [1:0]  bright;
    logic        enable;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;
    int          total = 0;
    int          bad = 0;

    localparam logic [6:0] GL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    sevenseg_scan #(.DIGITS(4), .SCAN_DIV(8), .GUARD(1), .BRIGHT_W(2)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .value      (value),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .enable     (enable),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pins after each tick show slot cycle c; pwm equals c%4 because slots and frames are multiples of 4.
    task automatic check_slot(input int d, input logic [6:0] gl, input logic dpn, input logic blk);
        for (int c = 0; c < 8; c++) begin
            logic       on;
            logic [3:0] an_exp;
            tick();
            on = enable && c >= 1 && c <= 6 && !blk && (bright == 2'd3 || (c % 4) < bright);
            an_exp = 4'hF;
            if (on) an_exp[d] = 1'b0;
            chk($sformatf("an d%0d c%0d", d, c), 32'(an), 32'(an_exp));
            chk($sformatf("seg d%0d c%0d", d, c), 32'(seg), on ? 32'(gl) : 32'h7F);
            chk($sformatf("dp_n d%0d c%0d", d, c), 32'(dp_n), on ? 32'(dpn) : 32'h1);
            chk($sformatf("frame_done d%0d c%0d", d, c), 32'(frame_done), (d == 3 && c == 7) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic check_frame(input logic [15:0] sv, input logic [3:0] sdp, input logic [3:0] blk);
        for (int d = 0; d < 4; d++)
            check_slot(d, GL[sv[4*d +: 4]], ~sdp[d], blk[d]);
    endtask

    initial begin
        nRST = 1'b0;
        value = 16'h12AF;
        dp = 4'h0;
        blank_lz = 1'b0;
        bright = 2'd3;
        enable = 1'b1;
        #22;
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset dp_n", 32'(dp_n), 32'h1);
        chk("reset an", 32'(an), 32'hF);
        chk("reset frame_done", 32'(frame_done), 32'h0);
        nRST = 1'b1;
        check_frame(16'h0000, 4'h0, 4'h0);
        value = 16'h0040;
        blank_lz = 1'b1;
        check_frame(16'h12AF, 4'h0, 4'h0);
        dp = 4'b1000;
        check_frame(16'h0040, 4'h0, 4'b1100);
        dp = 4'h0;
        value = 16'h1111;
        check_frame(16'h0040, 4'b1000, 4'b0100);
        blank_lz = 1'b0;
        check_slot(0, GL[1], 1'b1, 1'b0);
        check_slot(1, GL[1], 1'b1, 1'b0);
        value = 16'h2222;
        check_slot(2, GL[1], 1'b1, 1'b0);
        check_slot(3, GL[1], 1'b1, 1'b0);
        bright = 2'd1;
        check_frame(16'h2222, 4'h0, 4'h0);
        bright = 2'd0;
        check_frame(16'h2222, 4'h0, 4'h0);
        bright = 2'd3;
        enable = 1'b0;
        check_frame(16'h2222, 4'h0, 4'h0);
        enable = 1'b1;
        check_slot(0, GL[2], 1'b1, 1'b0);
        check_slot(1, GL[2], 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        chk("pre-reset an", 32'(an), 32'hB);
        chk("pre-reset seg", 32'(seg), 32'h24);
        nRST = 1'b0;
        #2;
        chk("async reset seg", 32'(seg), 32'h7F);
        chk("async reset dp_n", 32'(dp_n), 32'h1);
        chk("async reset an", 32'(an), 32'hF);
        chk("async reset frame_done", 32'(frame_done), 32'h0);
        @(posedge CLK);
        #2;
        nRST = 1'b1;
        check_frame(16'h0000, 4'h0, 4'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
